// File: rtl/plb_pkg.sv
// Shared definitions for the permuted lane buffer: state geometry, FSM
// states and the lane data type.
package plb_pkg;

    localparam int LANES  = 25;
    localparam int LANE_W = 64;
    localparam int IDX_W  = 5;

    // Mask value meaning every lane slot of the state has been written.
    localparam logic [LANES-1:0] FULL_MASK = '1;

    // Index of the final lane, which closes out a drain.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {
        FILL,
        DRAIN
    } plb_state_t;

    typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/lane_regfile.sv
// Storage for one 5x5 state of 64-bit lanes. One synchronous write port
// fed by the permutation stage and one asynchronous read port used by the
// drain side. Contents are deliberately not reset; the control logic never
// presents a slot before it has been written in the current fill.
import plb_pkg::*;

module lane_regfile (
    input  logic             clk,
    input  logic             i_wrEn,
    input  logic [IDX_W-1:0] i_wrAddr,
    input  lane_t            i_wrData,
    input  logic [IDX_W-1:0] i_rdAddr,
    output lane_t            o_rdData
);

    lane_t r_mem [LANES];

    // Capture a lane into its destination slot on an accepted write.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/permuted_lane_buffer.sv
// Permuted lane buffer: gathers 25 lanes written in scattered index order,
// then streams them out in ascending index order over valid/ready.
// Optional feature: define PLB_DUP_CHECK_EN to add the sticky err_dup
// output flagging writes to an already-filled slot.
import plb_pkg::*;

module permuted_lane_buffer (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LANE_W-1:0] wr_lane,
    output logic              wr_rdy,
    output logic [IDX_W-1:0]  fill_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [LANE_W-1:0] out_lane,
    output logic              out_last,
`ifdef PLB_DUP_CHECK_EN
    output logic              err_dup,
`endif
    output logic              err_range
);

    plb_state_t       r_state;
    plb_state_t       w_stateNext;
    logic [LANES-1:0] r_mask;
    logic [LANES-1:0] w_maskNext;
    logic [IDX_W-1:0] r_fillCnt;
    logic [IDX_W-1:0] w_fillCntNext;
    logic [IDX_W-1:0] r_rdPtr;
    logic [IDX_W-1:0] w_rdPtrNext;
    logic             r_errRange;
    logic             w_errRangeNext;
    logic             w_memWr;
    logic [LANES-1:0] w_slotOneHot;
    lane_t            w_rdLane;
`ifdef PLB_DUP_CHECK_EN
    logic             r_errDup;
    logic             w_errDupNext;
`endif

    assign w_slotOneHot = LANES'(1) << wr_idx;

    lane_regfile u_regfile (
        .clk      (clk),
        .i_wrEn   (w_memWr),
        .i_wrAddr (wr_idx),
        .i_wrData (wr_lane),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_rdLane)
    );

    // Next-state logic: FILL accepts scattered writes and tracks which slots
    // are populated; DRAIN walks the read pointer once per handshake and
    // re-arms the buffer after the last lane is taken.
    always_comb begin
        w_stateNext    = r_state;
        w_maskNext     = r_mask;
        w_fillCntNext  = r_fillCnt;
        w_rdPtrNext    = r_rdPtr;
        w_errRangeNext = r_errRange;
        w_memWr        = 1'b0;
`ifdef PLB_DUP_CHECK_EN
        w_errDupNext   = r_errDup;
`endif
        case (r_state)
            FILL: begin
                if (wr_en) begin
                    if (wr_idx < IDX_W'(LANES)) begin
                        w_memWr    = 1'b1;
                        w_maskNext = r_mask | w_slotOneHot;
                        if ((r_mask & w_slotOneHot) == '0) begin
                            w_fillCntNext = r_fillCnt + IDX_W'(1);
                        end
`ifdef PLB_DUP_CHECK_EN
                        else begin
                            w_errDupNext = 1'b1;
                        end
`endif
                        if (w_maskNext == FULL_MASK) begin
                            w_stateNext = DRAIN;
                        end
                    end else begin
                        w_errRangeNext = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (r_rdPtr == LAST_IDX) begin
                        w_maskNext    = '0;
                        w_fillCntNext = '0;
                        w_rdPtrNext   = '0;
                        w_stateNext   = FILL;
                    end else begin
                        w_rdPtrNext = r_rdPtr + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_stateNext = FILL;
            end
        endcase
    end

    // State register with synchronous reset; clearing the mask is what keeps
    // stale lane contents from ever being presented after an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_mask     <= '0;
            r_fillCnt  <= '0;
            r_rdPtr    <= '0;
            r_errRange <= 1'b0;
`ifdef PLB_DUP_CHECK_EN
            r_errDup   <= 1'b0;
`endif
        end else begin
            r_state    <= w_stateNext;
            r_mask     <= w_maskNext;
            r_fillCnt  <= w_fillCntNext;
            r_rdPtr    <= w_rdPtrNext;
            r_errRange <= w_errRangeNext;
`ifdef PLB_DUP_CHECK_EN
            r_errDup   <= w_errDupNext;
`endif
        end
    end

    assign wr_rdy    = (r_state == FILL);
    assign out_valid = (r_state == DRAIN);
    assign fill_cnt  = r_fillCnt;
    assign out_idx   = out_valid ? r_rdPtr : '0;
    assign out_lane  = out_valid ? w_rdLane : '0;
    assign out_last  = out_valid && (r_rdPtr == LAST_IDX);
    assign err_range = r_errRange;
`ifdef PLB_DUP_CHECK_EN
    assign err_dup   = r_errDup;
`endif

endmodule

// File: tb/tb_permuted_lane_buffer.sv
// Self-checking bench for permuted_lane_buffer. A set/array model of the
// buffer is compared against the DUT every cycle; drains are also logged
// and checked against hand-built expected lane tables.
// Define PLB_DUP_CHECK_EN to also exercise err_dup.
`timescale 1ns/1ps
import plb_pkg::*;

module tb_permuted_lane_buffer;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [LANE_W-1:0] wr_lane;
    logic              wr_rdy;
    logic [IDX_W-1:0]  fill_cnt;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [LANE_W-1:0] out_lane;
    logic              out_last;
    logic              err_range;
`ifdef PLB_DUP_CHECK_EN
    logic              err_dup;
`endif

    permuted_lane_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_lane   (wr_lane),
        .wr_rdy    (wr_rdy),
        .fill_cnt  (fill_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_lane  (out_lane),
        .out_last  (out_last),
`ifdef PLB_DUP_CHECK_EN
        .err_dup   (err_dup),
`endif
        .err_range (err_range)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Behavioural model: which slots hold data, their values, and where the
    // drain has got to.
    bit          mDrain;
    bit          mHave [LANES];
    logic [63:0] mData [LANES];
    int          mPtr;
    bit          mErrRange;
    bit          mErrDup;

    typedef struct {
        int          idx;
        logic [63:0] lane;
    } hs_t;
    hs_t hsLog [$];

    logic [63:0] expLane [LANES];

    function automatic int mCount();
        int c = 0;
        foreach (mHave[k]) if (mHave[k]) c++;
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every rising edge from the same inputs the DUT sees.
    always @(posedge clk) begin
        if (rst) begin
            mDrain = 1'b0;
            foreach (mHave[k]) mHave[k] = 1'b0;
            mPtr      = 0;
            mErrRange = 1'b0;
            mErrDup   = 1'b0;
        end else if (!mDrain) begin
            if (wr_en) begin
                if (int'(wr_idx) < LANES) begin
                    if (mHave[wr_idx]) mErrDup = 1'b1;
                    mHave[wr_idx] = 1'b1;
                    mData[wr_idx] = wr_lane;
                    if (mCount() == LANES) begin
                        mDrain = 1'b1;
                        mPtr   = 0;
                    end
                end else begin
                    mErrRange = 1'b1;
                end
            end
        end else if (out_ready) begin
            if (mPtr == LANES - 1) begin
                mDrain = 1'b0;
                mPtr   = 0;
                foreach (mHave[k]) mHave[k] = 1'b0;
            end else begin
                mPtr++;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("wr_rdy", wr_rdy, !mDrain);
            checkOutput("fill_cnt", fill_cnt, mCount());
            checkOutput("out_valid", out_valid, mDrain);
            checkOutput("out_idx", out_idx, mDrain ? mPtr : 0);
            checkOutput("out_lane", out_lane, mDrain ? mData[mPtr] : 64'h0);
            checkOutput("out_last", out_last, mDrain && (mPtr == LANES - 1));
            checkOutput("err_range", err_range, mErrRange);
`ifdef PLB_DUP_CHECK_EN
            checkOutput("err_dup", err_dup, mErrDup);
`endif
        end
    end

    // Record every completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hsLog.push_back('{int'(out_idx), out_lane});
        end
    end

    task automatic applyStimulus(input logic en, input int idx, input logic [63:0] data, input logic rdy);
        wr_en     = en;
        wr_idx    = 5'(idx);
        wr_lane   = data;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Fill all 25 slots in permutation order: newIdx = 5*((2i+3j)%5)+j.
    task automatic piFill(input logic [63:0] base);
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                int idx = 5 * ((2 * i + 3 * j) % 5) + j;
                if (n == 24) begin
                    checkOutput("preLastFillCnt", fill_cnt, 24);
                    checkOutput("preLastValid", out_valid, 0);
                end
                expLane[idx] = base + 64'(idx);
                applyStimulus(1'b1, idx, base + 64'(idx), 1'b0);
                n++;
            end
        end
        wr_en = 1'b0;
        checkOutput("validAfterFill", out_valid, 1);
        checkOutput("rdyAfterFill", wr_rdy, 0);
    endtask

    // Drain with out_ready always high (mode 0) or pattern 1,0,0 (mode 1).
    task automatic drainAll(input int mode);
        hsLog.delete();
        for (int c = 0; c < 200 && hsLog.size() < LANES; c++) begin
            applyStimulus(1'b0, 0, 64'h0, (mode == 0) ? 1'b1 : ((c % 3) == 0));
        end
        out_ready = 1'b0;
        checkOutput("drainCount", 64'(hsLog.size()), 64'd25);
        if (hsLog.size() == LANES) begin
            for (int k = 0; k < LANES; k++) begin
                checkOutput("drainIdx", 64'(hsLog[k].idx), 64'(k));
                checkOutput("drainLane", hsLog[k].lane, expLane[k]);
            end
        end
        checkOutput("rdyAfterDrain", wr_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_lane = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        checkEn = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rstWrRdy", wr_rdy, 1);
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstFillCnt", fill_cnt, 0);
        checkOutput("rstErrRange", err_range, 0);

        $display("[TB] pi-order fill, continuous drain");
        piFill(64'h1000);
        checkOutput("piLane0Literal", expLane[0], 64'h1000);
        drainAll(0);

        $display("[TB] backpressure drain");
        piFill(64'h2000);
        drainAll(1);

        $display("[TB] duplicate write to index 7");
        applyStimulus(1'b1, 7, 64'hAAAA, 1'b0);
        for (int k = 0; k < LANES; k++) begin
            if (k != 7) begin
                if (k == 24) begin
                    checkOutput("dupPreFillCnt", fill_cnt, 24);
                    checkOutput("dupPreValid", out_valid, 0);
                end
                expLane[k] = 64'h3000 + 64'(k);
                applyStimulus(1'b1, k, 64'h3000 + 64'(k), 1'b0);
                if (k == 12) applyStimulus(1'b1, 7, 64'hBBBB, 1'b0);
            end
        end
        wr_en = 1'b0;
        expLane[7] = 64'hBBBB;
        checkOutput("dupValid", out_valid, 1);
`ifdef PLB_DUP_CHECK_EN
        checkOutput("dupFlag", err_dup, 1);
`endif
        drainAll(0);

        $display("[TB] write during drain");
        piFill(64'h6000);
        applyStimulus(1'b1, 3, 64'hDEAD, 1'b0);
        wr_en = 1'b0;
        checkOutput("drainWrRdy", wr_rdy, 0);
        checkOutput("drainWrNoErr", err_range, 0);
        drainAll(0);
        checkOutput("drainWrLane3", expLane[3], 64'h6003);

        $display("[TB] out-of-range writes");
        for (int k = 0; k < 3; k++) begin
            expLane[k] = 64'h4000 + 64'(k);
            applyStimulus(1'b1, k, 64'h4000 + 64'(k), 1'b0);
        end
        applyStimulus(1'b1, 25, 64'hEEEE, 1'b0);
        applyStimulus(1'b1, 31, 64'hFFFF, 1'b0);
        wr_en = 1'b0;
        checkOutput("rangeErr", err_range, 1);
        checkOutput("rangeFillCnt", fill_cnt, 3);
        checkOutput("rangeNoDrain", out_valid, 0);
        for (int k = 3; k < LANES; k++) begin
            expLane[k] = 64'h4000 + 64'(k);
            applyStimulus(1'b1, k, 64'h4000 + 64'(k), 1'b0);
        end
        wr_en = 1'b0;
        drainAll(0);

        $display("[TB] mid-drain reset");
        piFill(64'h5000);
        hsLog.delete();
        for (int c = 0; c < 100 && hsLog.size() < 11; c++) begin
            applyStimulus(1'b0, 0, 64'h0, 1'b1);
        end
        checkOutput("midAccepted", 64'(hsLog.size()), 64'd11);
        if (hsLog.size() == 11) checkOutput("midLastIdx", 64'(hsLog[10].idx), 64'd10);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midRstValid", out_valid, 0);
        checkOutput("midRstFillCnt", fill_cnt, 0);
        checkOutput("midRstWrRdy", wr_rdy, 1);
        checkOutput("midRstErrRange", err_range, 0);
        piFill(64'h7000);
        drainAll(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
